// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // addi x0,x0,0 -- the bubble held in IF/ID when it is empty or flushed
    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    // Low two bits of every uncompressed RV32 encoding
    localparam logic [1:0] OPC_LOW = 2'b11;

    // Instruction words whose low bits are not 2'b11 are compressed and unsupported
    function automatic logic is_illegal(input logic [31:0] instr);
        return instr[1:0] != OPC_LOW;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures pc/instruction on load, clears to NOP on flush.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds contents whenever neither load nor flush is asserted.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            id_illegal
);

    // Load has priority over flush; the controller never asserts both at once
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_instr    <= NOP_INSTR;
            id_illegal  <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= pc + XLEN'(4);
            id_instr    <= instr;
            id_illegal  <= is_illegal(instr);
        end else if (flush) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the pc, drives imem, feeds decode through IF/ID with redirect/halt.
// Latency: instruction at pc appears on id_* one cycle after pc is on imem_addr; 1 instr/cycle.
// Backpressure: id_valid && !id_ready freezes pc and IF/ID; redirect always wins and flushes.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int            XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]   NOP_INSTR = FETCH_NOP
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic            id_illegal,
    output logic            misalign_err,
    output logic [31:0]     fetch_cnt
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            load, redir_flush, drain, misalign_nxt;
    logic            can_load, xfer;

    assign imem_addr = pc;
    assign can_load  = !id_valid || id_ready;
    assign xfer      = id_valid && id_ready;

    // Next-state, pc and IF/ID control decode
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        load         = 1'b0;
        redir_flush  = 1'b0;
        misalign_nxt = 1'b0;
        drain        = 1'b0;
        if (redirect_valid && (state != ST_RUN || 1'b1)) begin
            // Redirect is honoured identically in every state and always lands in RUN
            pc_nxt       = redirect_pc & ~XLEN'(3);
            redir_flush  = 1'b1;
            misalign_nxt = |redirect_pc[1:0];
            state_nxt    = ST_RUN;
        end else begin
            case (state)
                ST_BOOT: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        state_nxt = ST_HALT;
                    end else if (can_load) begin
                        load   = 1'b1;
                        pc_nxt = pc + XLEN'(4);
                    end
                end
                ST_HALT: begin
                    if (!halt_req) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
        // A consumed instruction not replaced by a new one leaves a bubble behind
        drain = !load && xfer;
    end

    // State, pc, misalign pulse and accepted-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misalign_err <= misalign_nxt;
            if (xfer) fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (redir_flush || drain),
        .pc          (pc),
        .instr       (imem_data),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_illegal  (id_illegal)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_illegal;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory image: fixed words at 0, 4 and the top word; elsewhere an address-tagged addi
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)         return 32'h0000_0013;
        if (a == 32'h4)         return 32'h00A0_0093;
        if (a == 32'hFFFF_FFFC) return 32'h0000_0001;
        return {a[23:0], 8'h13};
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .id_illegal     (id_illegal),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        @(negedge clk);
        repeat (3) step();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_mis", 32'(misalign_err), 32'd0);

        // Boot: one bubble cycle, then back-to-back fetch
        rst = 1'b1;
        step();
        chk("boot_valid", 32'(id_valid), 32'd0);
        chk("boot_addr", imem_addr, 32'h0);
        step();
        chk("f0_valid", 32'(id_valid), 32'd1);
        chk("f0_pc", id_pc, 32'h0);
        chk("f0_instr", id_instr, 32'h0000_0013);
        chk("f0_addr", imem_addr, 32'h4);
        step();
        chk("f1_pc", id_pc, 32'h4);
        chk("f1_instr", id_instr, 32'h00A0_0093);
        chk("f1_plus4", id_pc_plus4, 32'h8);
        chk("f1_cnt", fetch_cnt, 32'd1);
        step();
        chk("f2_pc", id_pc, 32'h8);
        chk("f2_cnt", fetch_cnt, 32'd2);

        // Stall three cycles at id_pc=8
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_cnt", fetch_cnt, 32'd2);
            chk("stall_valid", 32'(id_valid), 32'd1);
        end
        id_ready = 1'b1;
        step();
        chk("unstall_pc", id_pc, 32'hC);
        chk("unstall_cnt", fetch_cnt, 32'd3);

        // Redirect while decode is stalled: flush, no transfer
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        chk("rd_valid", 32'(id_valid), 32'd0);
        chk("rd_instr", id_instr, 32'h0000_0013);
        chk("rd_addr", imem_addr, 32'h40);
        chk("rd_cnt", fetch_cnt, 32'd3);
        chk("rd_mis", 32'(misalign_err), 32'd0);
        redirect_valid = 1'b0; id_ready = 1'b1;
        step();
        chk("rd_pc", id_pc, 32'h40);
        chk("rd_instr2", id_instr, mem_word(32'h40));
        chk("rd_addr2", imem_addr, 32'h44);

        // Misaligned redirect coincident with a transfer
        redirect_valid = 1'b1; redirect_pc = 32'h46;
        step();
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_addr", imem_addr, 32'h44);
        chk("mis_cnt", fetch_cnt, 32'd4);
        chk("mis_valid", 32'(id_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("mis_clr", 32'(misalign_err), 32'd0);
        chk("mis_pc", id_pc, 32'h44);

        // Halt with 0x1C pending
        redirect_valid = 1'b1; redirect_pc = 32'h1C;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pre_halt_pc", id_pc, 32'h1C);
        chk("pre_halt_addr", imem_addr, 32'h20);
        halt_req = 1'b1;
        step();
        chk("halt_cnt", fetch_cnt, 32'd6);
        chk("halt_valid", 32'(id_valid), 32'd0);
        chk("halt_addr", imem_addr, 32'h20);
        step();
        chk("halt_hold_addr", imem_addr, 32'h20);
        chk("halt_hold_valid", 32'(id_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("halt_rd_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0; halt_req = 1'b0;
        step();
        chk("resume_pc", id_pc, 32'h100);
        chk("resume_valid", 32'(id_valid), 32'd1);

        // Halt then release without redirect resumes from held pc
        halt_req = 1'b1;
        step();
        chk("halt2_cnt", fetch_cnt, 32'd7);
        halt_req = 1'b0;
        step();
        chk("halt2_valid", 32'(id_valid), 32'd0);
        chk("halt2_addr", imem_addr, 32'h104);
        step();
        chk("halt2_pc", id_pc, 32'h104);

        // Top-of-memory wrap with a compressed (illegal) word
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_cnt", fetch_cnt, 32'd8);
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_ill", 32'(id_illegal), 32'd1);
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        chk("wrap_instr", id_instr, 32'h0000_0001);
        chk("wrap_addr", imem_addr, 32'h0);
        step();
        chk("wrap_next_pc", id_pc, 32'h0);
        chk("wrap_next_ill", 32'(id_illegal), 32'd0);
        chk("wrap_next_cnt", fetch_cnt, 32'd9);

        // Reset mid-operation discards IF/ID and the pending transfer
        rst = 1'b0;
        step();
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_cnt", fetch_cnt, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_instr", id_instr, 32'h0000_0013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
